// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the write-back port arbiter: queue entry layout, grant encoding and a
// register-index one-hot helper.
package wb_port_arbiter_pkg;

    localparam int unsigned WB_AW = 5;
    localparam int unsigned WB_DW = 64;

    typedef struct packed {
        logic             young;
        logic [WB_AW-1:0] waddr;
        logic [WB_DW-1:0] wdata;
    } wb_entry_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_FIFO = 2'd1,
        G_LSU  = 2'd2
    } grant_e;

    function automatic logic [31:0] reg_onehot(input logic [WB_AW-1:0] addr);
        reg_onehot = 32'd1 << addr;
    endfunction

endpackage

// File: rtl/wb_order_fifo.sv
// In-order EXU result queue. Each entry carries a young bit marking it as younger than the
// outstanding load; all young bits can be cleared in one cycle when that load retires.
module wb_order_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    input  logic                          clear_young,
    output logic                          head_valid,
    output wb_entry_t                     head,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0]              valid_vec,
    output logic [DEPTH-1:0][WB_AW-1:0]   waddr_vec
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    rptr_q, wptr_q;
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] young_q, young_d;
    logic [WB_AW-1:0] waddr_q [DEPTH];
    logic [WB_DW-1:0] wdata_q [DEPTH];
    logic [PW-1:0]    idx;

    // An entry pushed in the same cycle as the load retires is already older than any new load.
    always_comb begin
        young_d = clear_young ? '0 : young_q;
        if (push) begin
            young_d[wptr_q] = push_entry.young & ~clear_young;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            young_q <= '0;
        end else if (flush) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            young_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
            young_q <= young_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            waddr_q[wptr_q] <= push_entry.waddr;
            wdata_q[wptr_q] <= push_entry.wdata;
        end
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx          = PW'(i);
            valid_vec[i] = {1'b0, idx - rptr_q} < count_q;
            waddr_vec[i] = waddr_q[i];
        end
    end

    assign head_valid = (count_q != '0);
    assign head.young = young_q[rptr_q];
    assign head.waddr = waddr_q[rptr_q];
    assign head.wdata = wdata_q[rptr_q];
    assign count      = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between queued EXU results and one outstanding load,
// retiring writes in program order and exporting a pending-write mask for hazard detection.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          exu_valid_i,
    output logic          exu_ready_o,
    input  logic [AW-1:0] exu_waddr_i,
    input  logic [DW-1:0] exu_wdata_i,
    input  logic          lsu_issue_i,
    input  logic          lsu_valid_i,
    output logic          lsu_ready_o,
    input  logic [AW-1:0] lsu_waddr_i,
    input  logic [DW-1:0] lsu_wdata_i,
    output logic          reg_we_o,
    output logic [AW-1:0] reg_waddr_o,
    output logic [DW-1:0] reg_wdata_o,
    output logic [31:0]   pend_mask_o,
    output logic          ld_pend_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                        ld_pend_q, ld_pend_d;
    logic                        reg_we_q;
    logic [AW-1:0]               reg_waddr_q;
    logic [DW-1:0]               reg_wdata_q;
    grant_e                      grant;
    logic                        push, pop, clear_young;
    wb_entry_t                   push_entry, head;
    logic                        head_valid;
    logic [CW-1:0]               count;
    logic [DEPTH-1:0]            valid_vec;
    logic [DEPTH-1:0][WB_AW-1:0] waddr_vec;
    logic [31:0]                 pend_mask;

    assign exu_ready_o = (count < CW'(DEPTH)) && !flush_i;
    // Writes to x0 are handshaken but never occupy the queue.
    assign push        = exu_valid_i && exu_ready_o && (exu_waddr_i != '0);

    assign push_entry.young = ld_pend_q;
    assign push_entry.waddr = exu_waddr_i;
    assign push_entry.wdata = exu_wdata_i;

    always_comb begin
        grant = G_NONE;
        if (!flush_i) begin
            if (head_valid && !head.young) begin
                grant = G_FIFO;
            end else if (lsu_valid_i) begin
                grant = G_LSU;
            end
        end
    end

    assign pop         = (grant == G_FIFO);
    assign clear_young = (grant == G_LSU);
    assign lsu_ready_o = (grant == G_LSU);

    wb_order_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush_i),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .clear_young (clear_young),
        .head_valid  (head_valid),
        .head        (head),
        .count       (count),
        .valid_vec   (valid_vec),
        .waddr_vec   (waddr_vec)
    );

    // A new issue in the retiring cycle keeps the load-pending state set.
    always_comb begin
        ld_pend_d = ld_pend_q;
        if (flush_i) begin
            ld_pend_d = 1'b0;
        end else if (grant == G_LSU) begin
            ld_pend_d = lsu_issue_i;
        end else if (lsu_issue_i) begin
            ld_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_pend_q <= 1'b0;
        end else begin
            ld_pend_q <= ld_pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            unique case (grant)
                G_FIFO: begin
                    reg_we_q    <= 1'b1;
                    reg_waddr_q <= head.waddr;
                    reg_wdata_q <= head.wdata;
                end
                G_LSU: begin
                    reg_we_q    <= (lsu_waddr_i != '0);
                    reg_waddr_q <= lsu_waddr_i;
                    reg_wdata_q <= lsu_wdata_i;
                end
                default: reg_we_q <= 1'b0;
            endcase
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_vec[i]) pend_mask |= reg_onehot(waddr_vec[i]);
        end
        if (reg_we_q) pend_mask |= reg_onehot(reg_waddr_q);
        pend_mask[0] = 1'b0;
    end

    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign pend_mask_o = pend_mask;
    assign ld_pend_o   = ld_pend_q;

    a_single_load: assert property (@(posedge clk) disable iff (!rst_n)
        !(lsu_issue_i && ld_pend_q && (grant != G_LSU) && !flush_i))
        else $error("lsu_issue_i while a load is already outstanding");

endmodule
